pc_control: RTL

Program-counter and branch-resolution unit for the WISC 16-bit single-cycle core; the consumer of the opcode decoder's Branch/Br/PCStore/halt outputs. Holds the PC, the Z/V/N flag register and the run/halt state. Evaluates the 3-bit condition code for B and BR, and produces the next fetch address plus the PC+2 value written back by PCS. Sits between instruction memory (drives its address) and the ALU (samples its flag results).

---
 rtl/wisc_pkg.sv | 41 ++++
 rtl/branch_cond.sv | 37 +++
 rtl/pc_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared constants for the WISC 16-bit core.
// Holds the opcode map, branch condition codes, flag-register bit positions and
// the run/halt state encoding used by the PC control unit.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_UNC  = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic {
    StRun,
    StHalt
  } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator.
// Purely combinational: decodes the 3-bit condition code against the {Z,V,N}
// flag register and reports whether the condition holds.
// Ports:
//   ccc   in  3  condition code (instruction[11:9])
//   flags in  3  {Z,V,N} flag register
//   cond  out 1  condition is true
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond = 1'b0;
    unique case (ccc)
      CC_NE:   cond = ~z;
      CC_EQ:   cond = z;
      CC_GT:   cond = ~z & ~n;
      CC_LT:   cond = n;
      CC_GTE:  cond = z | ~n;
      CC_LTE:  cond = n | z;
      CC_OVFL: cond = v;
      CC_UNC:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Program-counter and branch-resolution unit for the WISC single-cycle core.
// Holds the PC, the {Z,V,N} flag register and the run/halt state; resolves B/BR
// and produces the next fetch address plus the PC+2 write-back value for PCS.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   opcode, ccc, imm9   fields of the current instruction
//   br_target           rs value used as the BR target
//   alu_z/alu_v/alu_n   ALU flag results for the current instruction
//   stall               hold PC, flags and state (ignored once halted)
//   pc, pc_plus2        registered fetch address and its successor
//   branch_taken        current B/BR redirects the PC
//   flags, halted       flag register and halt status
module pc_control
  import wisc_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [2:0]        ccc,
  input  logic [8:0]        imm9,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              branch_taken,
  output logic [2:0]        flags,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-1){1'b0}}, 1'b1};

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        flags_q, flags_d;

  logic              run;
  logic              cond;
  logic              is_branch;
  logic [ADDR_W-1:0] b_offset;
  logic [ADDR_W-1:0] target;

  branch_cond u_branch_cond (
    .ccc   (ccc),
    .flags (flags_q),
    .cond  (cond)
  );

  assign run       = (state_q == StRun);
  assign is_branch = (opcode[3:1] == 3'b110);
  assign pc_plus2  = pc_q + ADDR_W'(2);

  // Word offset: sign-extend imm9 and scale by two bytes.
  assign b_offset  = {{(ADDR_W-10){imm9[8]}}, imm9, 1'b0};

  assign branch_taken = run & is_branch & cond;

  always_comb begin
    target = pc_plus2;
    if (branch_taken) begin
      if (opcode == OP_B) target = pc_plus2 + b_offset;
      else                target = br_target & ALIGN_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (run && !stall) begin
      if (opcode == OP_HLT) begin
        // PC stays on the HLT address.
        state_d = StHalt;
      end else begin
        pc_d = target;
      end
      unique case (opcode)
        OP_ADD, OP_SUB: flags_d = {alu_z, alu_v, alu_n};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLAG_Z] = alu_z;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign halted = (state_q == StHalt);

endmodule
